serdes_clk_ctrl: RTL and testbench
==================================

// Module: serdes_clk_ctrl
// PURPOSE
//  - Sequencer for the div-2 SerDes clock generator: drives its async reset and clock-gate enable in a safe order.
//  - Reset held N cycles, settle gap, then enable. On stop: gate first, drain, then reset. Resync = stop + start, automatic.
//  - Sits in the always-on control clock domain, between the config/CSR logic and each clock-gen instance.
// PARAMETERS
//  - RstCycles     default 8   cycles o_div_rst held high in RST_HOLD (>=1)
//  - SettleCycles  default 4   cycles between reset release and enable assertion (>=1)
//  - DrainCycles   default 4   cycles between enable removal and reset assertion (>=1)
//  - CntW          default 8   width of restart counter (optional feature only)
// PORTS
//  - i_clk          in   1     control clock, single clock domain
//  - i_rst_n        in   1     asynchronous active-low reset
//  - i_start        in   1     level/pulse; request clock-gen bring-up
//  - i_stop         in   1     level/pulse; request clock-gen shutdown
//  - i_resync       in   1     pulse; request full restart (drain, reset, settle, enable)
//  - o_div_rst      out  1     to divider reset (active-high), registered
//  - o_div_en       out  1     to divider clock-gate enable, registered
//  - o_ready        out  1     1 only in RUN
//  - o_busy         out  1     1 in RST_HOLD, SETTLE, DRAIN
//  - o_state        out  3     current state encoding (debug)
//  - o_restart_cnt  out  CntW  number of completed bring-ups (SERDES_CLK_CTRL_STATUS_EN only)
// BEHAVIOUR
//  - Reset (i_rst_n=0, async): state=OFF, o_div_rst=1, o_div_en=0, o_ready=0, o_busy=0, timer=0, resync_pend=0, o_restart_cnt=0.
//  - States: OFF=0, RST_HOLD=1, SETTLE=2, RUN=3, DRAIN=4. All outputs are decoded from the next state and registered, so they change in the same cycle the state register changes.
//  - OFF: div_rst=1, en=0. i_start & ~i_stop -> RST_HOLD, timer loaded RstCycles-1.
//  - RST_HOLD: div_rst=1, en=0. At timer==0 -> SETTLE, timer=SettleCycles-1. i_stop -> OFF immediately.
//  - SETTLE: div_rst=0, en=0. At timer==0 -> RUN. i_stop -> OFF immediately; enable is never asserted.
//  - RUN: div_rst=0, en=1, ready=1. i_stop -> DRAIN with resync_pend=0. i_resync -> DRAIN with resync_pend=1. Timer=DrainCycles-1.
//  - DRAIN: div_rst=0, en=0. At timer==0: if resync_pend, go to RST_HOLD (timer=RstCycles-1, resync_pend cleared); else go to OFF.
//  - Start to first o_div_en=1 latency: 1+RstCycles+SettleCycles cycles.
//  - Priority: i_stop > i_resync > i_start. i_stop in DRAIN clears resync_pend. i_start/i_resync in DRAIN are ignored. i_resync in OFF/RST_HOLD/SETTLE is ignored.
//  - o_div_rst and o_div_en are never both 1, and never both toggle in the same cycle. Verification must assert this every cycle.
//  - Timer width is $clog2(max(RstCycles,SettleCycles,DrainCycles)+1). The timer decrements only in timed states and saturates at 0.
//  - Illegal o_state encodings (5-7) return to OFF on the next cycle.
//  - Reset asserted mid-sequence forces OFF asynchronously, so the divider returns to reset immediately.
// CONFIGURATION
//  - `SERDES_CLK_CTRL_STATUS_EN defined: o_restart_cnt increments (wrapping at 2^CntW) on each SETTLE->RUN transition.
//  - Macro undefined: the o_restart_cnt port and its counter are absent; the rest of the behaviour is identical.
// STRUCTURE
//  - Shared package serdes_clk_pkg: state encoding localparams (ST_OFF..ST_DRAIN), state width 3.
//  - Single sub-module serdes_clk_ctrl_timer: loadable down-counter with load value, dec enable and zero flag.
//  - The FSM and output registers stay in the top module. There is no other hierarchy.
// TESTING
//  - Bring-up: defaults, i_start pulse at cycle 10. o_div_rst falls at cycle 19 and o_div_en rises at cycle 23; o_ready=1 and o_state=3.
//  - Shutdown: in RUN, pulse i_stop. Next cycle o_div_en=0. 4 cycles later o_div_rst=1 and o_state=0.
//  - Resync: in RUN, pulse i_resync. Required sequence: en=0 for 4 cycles, div_rst=1 for 8, 4-cycle settle, then en=1. o_restart_cnt goes 1->2.
//  - Abort: i_stop during SETTLE at cycle 3 -> OFF next cycle; o_div_en stays 0 throughout.
//  - Conflict: i_start and i_stop high in the same cycle while in OFF -> remains OFF. i_stop in DRAIN after i_resync -> ends in OFF.
//  - Async reset: drop i_rst_n mid-RUN. Outputs go to div_rst=1, en=0 without a clock edge; the mutual-exclusion assertion holds throughout.

Source files
------------

// File: rtl/serdes_clk_pkg.sv
// Shared definitions for the SerDes div-2 clock-generator sequencer:
// state encoding and a small constant helper for timer sizing.
package serdes_clk_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF      = 3'd0,
    ST_RST_HOLD = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_RUN      = 3'd3,
    ST_DRAIN    = 3'd4
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serdes_clk_ctrl_timer.sv
// Loadable saturating down-counter used for the hold, settle and drain intervals.
module serdes_clk_ctrl_timer #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= i_load_val;
    end else if (i_dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign o_zero = (cnt == '0);

endmodule

// File: rtl/serdes_clk_ctrl.sv
// Sequencer for the div-2 SerDes clock generator: orders divider reset and clock-gate enable.
// Optional restart counter output enabled by defining SERDES_CLK_CTRL_STATUS_EN.
module serdes_clk_ctrl
  import serdes_clk_pkg::*;
#(
  parameter int unsigned RstCycles    = 8,
  parameter int unsigned SettleCycles = 4,
  parameter int unsigned DrainCycles  = 4,
  parameter int unsigned CntW         = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_resync,
  output logic               o_div_rst,
  output logic               o_div_en,
  output logic               o_ready,
  output logic               o_busy,
  output logic [STATE_W-1:0] o_state
`ifdef SERDES_CLK_CTRL_STATUS_EN
  ,
  output logic [CntW-1:0]    o_restart_cnt
`endif
);

  localparam int unsigned TimerW = $clog2(max3(RstCycles, SettleCycles, DrainCycles) + 1);
  localparam logic [TimerW-1:0] RstLoad    = TimerW'(RstCycles - 1);
  localparam logic [TimerW-1:0] SettleLoad = TimerW'(SettleCycles - 1);
  localparam logic [TimerW-1:0] DrainLoad  = TimerW'(DrainCycles - 1);

  state_e              state, state_n;
  logic                resync_pend, resync_pend_n;
  logic                t_load, t_dec, t_zero;
  logic [TimerW-1:0]   t_load_val;

  serdes_clk_ctrl_timer #(.W(TimerW)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (t_load),
    .i_load_val (t_load_val),
    .i_dec      (t_dec),
    .o_zero     (t_zero)
  );

  always_comb begin
    state_n       = state;
    resync_pend_n = resync_pend;
    t_load        = 1'b0;
    t_load_val    = '0;
    case (state)
      ST_OFF: begin
        if (i_start && !i_stop) begin
          state_n    = ST_RST_HOLD;
          t_load     = 1'b1;
          t_load_val = RstLoad;
        end
      end
      ST_RST_HOLD: begin
        if (i_stop) begin
          state_n = ST_OFF;
        end else if (t_zero) begin
          state_n    = ST_SETTLE;
          t_load     = 1'b1;
          t_load_val = SettleLoad;
        end
      end
      ST_SETTLE: begin
        if (i_stop) begin
          state_n = ST_OFF;
        end else if (t_zero) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_stop || i_resync) begin
          state_n       = ST_DRAIN;
          resync_pend_n = !i_stop;
          t_load        = 1'b1;
          t_load_val    = DrainLoad;
        end
      end
      ST_DRAIN: begin
        // A stop during drain cancels a pending resync even on the final drain cycle.
        if (i_stop) begin
          resync_pend_n = 1'b0;
        end
        if (t_zero) begin
          if (resync_pend_n) begin
            state_n       = ST_RST_HOLD;
            resync_pend_n = 1'b0;
            t_load        = 1'b1;
            t_load_val    = RstLoad;
          end else begin
            state_n = ST_OFF;
          end
        end
      end
      default: begin
        state_n       = ST_OFF;
        resync_pend_n = 1'b0;
      end
    endcase
  end

  assign t_dec = !t_load &&
                 ((state == ST_RST_HOLD) || (state == ST_SETTLE) || (state == ST_DRAIN));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_OFF;
      resync_pend <= 1'b0;
      o_div_rst   <= 1'b1;
      o_div_en    <= 1'b0;
      o_ready     <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_n;
      resync_pend <= resync_pend_n;
      o_div_rst   <= (state_n == ST_OFF) || (state_n == ST_RST_HOLD);
      o_div_en    <= (state_n == ST_RUN);
      o_ready     <= (state_n == ST_RUN);
      o_busy      <= (state_n == ST_RST_HOLD) || (state_n == ST_SETTLE) ||
                     (state_n == ST_DRAIN);
    end
  end

  assign o_state = state;

`ifdef SERDES_CLK_CTRL_STATUS_EN
  logic [CntW-1:0] restart_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      restart_cnt <= '0;
    end else if ((state == ST_SETTLE) && (state_n == ST_RUN)) begin
      restart_cnt <= restart_cnt + CntW'(1);
    end
  end

  assign o_restart_cnt = restart_cnt;
`endif

endmodule

// File: tb/tb_serdes_clk_ctrl.sv
// Self-checking bench for serdes_clk_ctrl: table-driven sequences plus latency and async-reset cases.
module tb_serdes_clk_ctrl;

  localparam logic [2:0] S_OFF = 3'd0, S_HOLD = 3'd1, S_SETTLE = 3'd2, S_RUN = 3'd3, S_DRAIN = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, stop = 1'b0, resync = 1'b0;
  logic       div_rst, div_en, ready, busy;
  logic [2:0] st;
`ifdef SERDES_CLK_CTRL_STATUS_EN
  logic [7:0] rcnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serdes_clk_ctrl #(
    .RstCycles    (8),
    .SettleCycles (4),
    .DrainCycles  (4),
    .CntW         (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_stop        (stop),
    .i_resync      (resync),
    .o_div_rst     (div_rst),
    .o_div_en      (div_en),
    .o_ready       (ready),
    .o_busy        (busy),
    .o_state       (st)
`ifdef SERDES_CLK_CTRL_STATUS_EN
    ,
    .o_restart_cnt (rcnt)
`endif
  );

  typedef struct {
    logic       start, stop, resync;
    int         reps;
    logic [2:0] st;
    int         cnt;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic       rst, en, rdy, bsy;
    logic [7:0] cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic exp_t mk_exp(input logic [2:0] s, input int c);
    exp_t e;
    e.st  = s;
    e.rst = (s == S_OFF) || (s == S_HOLD);
    e.en  = (s == S_RUN);
    e.rdy = (s == S_RUN);
    e.bsy = (s == S_HOLD) || (s == S_SETTLE) || (s == S_DRAIN);
    e.cnt = c[7:0];
    return e;
  endfunction

  task automatic add(input logic s, input logic p, input logic r, input int n,
                     input logic [2:0] es, input int c);
    vec_t v;
    v.start = s; v.stop = p; v.resync = r; v.reps = n; v.st = es; v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic compare_front(input string name, input int idx);
    exp_t e;
    logic ok;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s[%0d]: scoreboard empty, no expected value", name, idx);
      return;
    end
    e  = sb.pop_front();
    ok = (st === e.st) && (div_rst === e.rst) && (div_en === e.en) &&
         (ready === e.rdy) && (busy === e.bsy);
`ifdef SERDES_CLK_CTRL_STATUS_EN
    ok = ok && (rcnt === e.cnt);
    if (!ok) begin
      errors++;
      $display("FAIL %s[%0d]: got st=%0d rst=%b en=%b rdy=%b busy=%b cnt=%0d want st=%0d rst=%b en=%b rdy=%b busy=%b cnt=%0d",
               name, idx, st, div_rst, div_en, ready, busy, rcnt,
               e.st, e.rst, e.en, e.rdy, e.bsy, e.cnt);
    end
`else
    if (!ok) begin
      errors++;
      $display("FAIL %s[%0d]: got st=%0d rst=%b en=%b rdy=%b busy=%b want st=%0d rst=%b en=%b rdy=%b busy=%b",
               name, idx, st, div_rst, div_en, ready, busy,
               e.st, e.rst, e.en, e.rdy, e.bsy);
    end
`endif
  endtask

  task automatic step(input logic s, input logic p, input logic r, input exp_t e,
                      input string name, input int idx);
    @(negedge clk);
    start = s; stop = p; resync = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_front(name, idx);
  endtask

  // Enable and divider reset must never be high together, including across async reset.
  always @(div_rst or div_en) begin
    assert (!(div_rst === 1'b1 && div_en === 1'b1))
    else begin
      errors++;
      $display("FAIL mutex: rst=%b en=%b both high", div_rst, div_en);
    end
  end

  logic prev_rst, prev_en, prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((div_rst === 1'b1 && div_en === 1'b1) ||
          (prev_valid && (div_rst !== prev_rst) && (div_en !== prev_en))) begin
        errors++;
        $display("FAIL toggle: rst %b->%b en %b->%b", prev_rst, div_rst, prev_en, div_en);
      end
    end
    prev_rst   = div_rst;
    prev_en    = div_en;
    prev_valid = rst_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    // bring-up, then shutdown
    add(0,0,0,10,S_OFF,0);
    add(1,0,0, 1,S_HOLD,0);   add(0,0,0, 7,S_HOLD,0);
    add(0,0,0, 4,S_SETTLE,0); add(0,0,0, 3,S_RUN,1);
    add(0,1,0, 1,S_DRAIN,1);  add(0,0,0, 3,S_DRAIN,1); add(0,0,0, 2,S_OFF,1);
    // start+stop conflict, resync ignored in OFF, stop during hold
    add(1,1,0, 2,S_OFF,1);    add(0,0,1, 2,S_OFF,1);
    add(1,0,0, 1,S_HOLD,1);   add(0,0,0, 2,S_HOLD,1);  add(0,1,0, 1,S_OFF,1);
    // abort on third settle cycle
    add(1,0,0, 1,S_HOLD,1);   add(0,0,0, 7,S_HOLD,1);
    add(0,0,0, 2,S_SETTLE,1); add(0,1,0, 1,S_OFF,1);   add(0,0,0, 1,S_OFF,1);
    // bring-up with resync ignored during settle
    add(1,0,0, 1,S_HOLD,1);   add(0,0,0, 7,S_HOLD,1);
    add(0,0,0, 1,S_SETTLE,1); add(0,0,1, 1,S_SETTLE,1); add(0,0,0, 2,S_SETTLE,1);
    add(0,0,0, 2,S_RUN,2);
    // resync: drain 4 (start ignored), hold 8, settle 4, run
    add(0,0,1, 1,S_DRAIN,2);  add(1,0,0, 1,S_DRAIN,2); add(0,0,0, 2,S_DRAIN,2);
    add(0,0,0, 8,S_HOLD,2);   add(0,0,0, 4,S_SETTLE,2); add(0,0,0, 2,S_RUN,3);
    // resync then stop inside drain ends in OFF
    add(0,0,1, 1,S_DRAIN,3);  add(0,0,0, 1,S_DRAIN,3); add(0,1,0, 1,S_DRAIN,3);
    add(0,0,0, 1,S_DRAIN,3);  add(0,0,0, 2,S_OFF,3);
    // stop and resync together in RUN: stop wins
    add(1,0,0, 1,S_HOLD,3);   add(0,0,0, 7,S_HOLD,3);  add(0,0,0, 4,S_SETTLE,3);
    add(0,0,0, 1,S_RUN,4);    add(0,1,1, 1,S_DRAIN,4); add(0,0,0, 3,S_DRAIN,4);
    add(0,0,0, 2,S_OFF,4);

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(mk_exp(S_OFF, 0));
    compare_front("reset", 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        step(tbl[i].start, tbl[i].stop, tbl[i].resync, mk_exp(tbl[i].st, tbl[i].cnt), "vec", i);
      end
    end

    // start-to-enable latency, bounded wait
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      start = 1'b0;
      if (div_en === 1'b1) break;
    end
    checks++;
    if (lat != 13) begin
      errors++;
      $display("FAIL latency: got %0d cycles want 13", lat);
    end
    sb.push_back(mk_exp(S_RUN, 5));
    compare_front("run_after_latency", 0);

    // async reset mid-RUN: outputs must change without a clock edge
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    sb.push_back(mk_exp(S_OFF, 0));
    compare_front("async_rst", 0);
    @(posedge clk);
    #1;
    sb.push_back(mk_exp(S_OFF, 0));
    compare_front("async_rst_hold", 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, mk_exp(S_OFF, 0), "post_rst", 0);
    step(1, 0, 0, mk_exp(S_HOLD, 0), "post_rst", 1);
    step(0, 0, 0, mk_exp(S_HOLD, 0), "post_rst", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
